// File: rtl/cache_fill_if.sv
// Signals between one cache fill engine, the CPU miss logic, main memory and the cache arrays.
interface cache_fill_if #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              fsm_busy;
    logic              mem_req;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_valid;
    logic [15:0]       memory_data;
    logic              write_data_array;
    logic [IDX_W-1:0]  data_word_index;
    logic [15:0]       fill_data;
    logic              write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_valid, memory_data,
        output fsm_busy, mem_req, memory_address,
               write_data_array, data_word_index, fill_data, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_valid, memory_data,
        input  fsm_busy, mem_req, memory_address,
               write_data_array, data_word_index, fill_data, write_tag_array
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss engine: stalls the CPU, streams one block from memory into the data array,
// then writes the tag/valid entry.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    cache_fill_if.master bus
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = IDX_W + 1;
    localparam logic [IDX_W:0]    WORDS     = (IDX_W + 1)'(BLOCK_WORDS);
    localparam logic [IDX_W:0]    LAST_WORD = (IDX_W + 1)'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(2 * BLOCK_WORDS - 1);
    localparam logic [IDX_W:0]    CNT_ONE   = {{IDX_W{1'b0}}, 1'b1};

    typedef enum logic {IDLE, FILL} state_t;

    state_t            stateReg, stateNext;
    logic [ADDR_W-1:0] baseReg, baseNext;
    logic [IDX_W:0]    reqCountReg, reqCountNext;
    logic [IDX_W:0]    rcvCountReg, rcvCountNext;
    logic [IDX_W-1:0]  reqWord;
    logic              fsmBusy, memReq, writeData, writeTag;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            baseReg     <= '0;
            reqCountReg <= '0;
            rcvCountReg <= '0;
        end else begin
            stateReg    <= stateNext;
            baseReg     <= baseNext;
            reqCountReg <= reqCountNext;
            rcvCountReg <= rcvCountNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        baseNext     = baseReg;
        reqCountNext = reqCountReg;
        rcvCountNext = rcvCountReg;
        fsmBusy      = 1'b0;
        memReq       = 1'b0;
        writeData    = 1'b0;
        writeTag     = 1'b0;
        unique case (stateReg)
            IDLE: begin
                fsmBusy = bus.miss_detected;
                if (bus.miss_detected) begin
                    baseNext     = bus.miss_address & ~OFF_MASK;
                    reqCountNext = '0;
                    rcvCountNext = '0;
                    stateNext    = FILL;
                end
            end
            FILL: begin
                fsmBusy = 1'b1;
                if (reqCountReg < WORDS) begin
                    memReq       = 1'b1;
                    reqCountNext = reqCountReg + CNT_ONE;
                end
                // Reception is driven purely by memory_valid; it may overlap issuing.
                if (bus.memory_valid) begin
                    writeData    = 1'b1;
                    rcvCountNext = rcvCountReg + CNT_ONE;
                    if (rcvCountReg == LAST_WORD) begin
                        writeTag  = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Once every request is out, the address output parks on the last one issued.
    assign reqWord = (reqCountReg >= WORDS) ? LAST_WORD[IDX_W-1:0] : reqCountReg[IDX_W-1:0];

    assign bus.fsm_busy         = fsmBusy;
    assign bus.mem_req          = memReq;
    assign bus.memory_address   = baseReg + {{(ADDR_W - OFF_W){1'b0}}, reqWord, 1'b0};
    assign bus.write_data_array = writeData;
    assign bus.data_word_index  = rcvCountReg[IDX_W-1:0];
    assign bus.fill_data        = bus.memory_data;
    assign bus.write_tag_array  = writeTag;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Checks cache_fill_fsm (BLOCK_WORDS=8 and 4) against a block-level fill model with a latency memory.
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_fill_if #(.ADDR_W(16), .BLOCK_WORDS(8)) bus8 ();
    cache_fill_if #(.ADDR_W(16), .BLOCK_WORDS(4)) bus4 ();

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    cache_fill_fsm #(.BLOCK_WORDS(4), .ADDR_W(16)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic        missDrv[2];
    logic [15:0] missAddrDrv[2];
    logic        memValidDrv[2];
    logic [15:0] memDataDrv[2];

    assign bus8.miss_detected = missDrv[0];
    assign bus8.miss_address  = missAddrDrv[0];
    assign bus8.memory_valid  = memValidDrv[0];
    assign bus8.memory_data   = memDataDrv[0];
    assign bus4.miss_detected = missDrv[1];
    assign bus4.miss_address  = missAddrDrv[1];
    assign bus4.memory_valid  = memValidDrv[1];
    assign bus4.memory_data   = memDataDrv[1];

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    string dutName[2] = '{"bw8", "bw4"};
    int    bw[2]      = '{8, 4};

    // stimulus requests applied by step()
    bit          rstReq;
    bit          missReq[2];
    logic [15:0] missAddrReq[2];
    bit          spurReq[2];
    int          latModeReq[2];

    // reference model: block-level view of one fill per DUT
    bit          inFill[2];
    int          issued[2];
    int          rcvd[2];
    logic [15:0] base[2];
    logic [15:0] lastAddr[2];
    bit          justDone[2];
    int          doneCount[2];
    int          tagCycle[2];

    // memory: in-order returns, per-request ready cycle
    logic [15:0] memAddr[2][32];
    int          memReady[2][32];
    int          memIssued[2];
    int          memReturned[2];
    int          lastReady[2];
    int          latMode[2];
    logic [15:0] salt[2];

    bit          obsBusy[2], obsReq[2], obsWr[2], obsTag[2];
    logic [15:0] obsAddr[2], obsFill[2];
    int          obsIdx[2];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] wordAt(input logic [15:0] a, input logic [15:0] s);
        return (a * 16'h9E37) ^ s;
    endfunction

    task automatic sampleOutputs();
        obsBusy[0] = bus8.fsm_busy;  obsReq[0] = bus8.mem_req;  obsAddr[0] = bus8.memory_address;
        obsWr[0]   = bus8.write_data_array; obsIdx[0] = int'(bus8.data_word_index);
        obsFill[0] = bus8.fill_data; obsTag[0] = bus8.write_tag_array;
        obsBusy[1] = bus4.fsm_busy;  obsReq[1] = bus4.mem_req;  obsAddr[1] = bus4.memory_address;
        obsWr[1]   = bus4.write_data_array; obsIdx[1] = int'(bus4.data_word_index);
        obsFill[1] = bus4.fill_data; obsTag[1] = bus4.write_tag_array;
    endtask

    task automatic modelCheck(input int d);
        bit          expReq, expWr, expTag;
        logic [15:0] expAddr;
        int          rdy;
        string       n = dutName[d];
        checkEq({n, ".busy"}, obsBusy[d], inFill[d] ? 1'b1 : missDrv[d]);
        expReq  = inFill[d] && (issued[d] < bw[d]);
        expAddr = expReq ? 16'(base[d] + 2 * issued[d]) : lastAddr[d];
        checkEq({n, ".req"}, obsReq[d], expReq);
        checkEq({n, ".addr"}, obsAddr[d], expAddr);
        expWr  = inFill[d] && memValidDrv[d];
        expTag = expWr && (rcvd[d] == bw[d] - 1);
        checkEq({n, ".wr"}, obsWr[d], expWr);
        checkEq({n, ".tag"}, obsTag[d], expTag);
        if (expWr) begin
            checkEq({n, ".idx"}, obsIdx[d], rcvd[d]);
            checkEq({n, ".fill"}, obsFill[d], memDataDrv[d]);
        end
        // memory serves whatever the DUT actually requested
        if (obsReq[d] && memIssued[d] < 32) begin
            case (latMode[d])
                1:       rdy = cyc + $urandom_range(1, 6);
                2:       rdy = cyc + 4 + ((memIssued[d] == 3) ? 3 : 0);
                default: rdy = cyc + 4;
            endcase
            if (rdy <= lastReady[d]) rdy = lastReady[d] + 1;
            memAddr[d][memIssued[d]]  = obsAddr[d];
            memReady[d][memIssued[d]] = rdy;
            lastReady[d] = rdy;
            memIssued[d]++;
        end
        justDone[d] = 1'b0;
        if (rst) begin
            inFill[d] = 1'b0; issued[d] = 0; rcvd[d] = 0; lastAddr[d] = 16'h0;
            memIssued[d] = 0; memReturned[d] = 0; lastReady[d] = 0;
        end else if (!inFill[d] && missDrv[d]) begin
            inFill[d]  = 1'b1;
            base[d]    = missAddrDrv[d] - (missAddrDrv[d] % 16'(2 * bw[d]));
            issued[d]  = 0;
            rcvd[d]    = 0;
            memIssued[d] = 0; memReturned[d] = 0; lastReady[d] = 0;
            latMode[d] = latModeReq[d];
            salt[d]    = 16'($urandom);
        end else if (inFill[d]) begin
            if (expReq) begin
                lastAddr[d] = expAddr;
                issued[d]++;
            end
            if (expWr) begin
                rcvd[d]++;
                if (expTag) begin
                    inFill[d]   = 1'b0;
                    justDone[d] = 1'b1;
                    tagCycle[d] = cyc;
                    doneCount[d]++;
                    $display("[TB] %s fill base=%04h done at cycle %0d", n, base[d], cyc);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst = rstReq;
        for (int d = 0; d < 2; d++) begin
            missDrv[d]     = missReq[d];
            missAddrDrv[d] = missAddrReq[d];
            if (memReturned[d] < memIssued[d] && memReady[d][memReturned[d]] <= cyc) begin
                memValidDrv[d] = 1'b1;
                memDataDrv[d]  = wordAt(memAddr[d][memReturned[d]], salt[d]);
                memReturned[d]++;
            end else begin
                memValidDrv[d] = spurReq[d] && !inFill[d];
                memDataDrv[d]  = 16'($urandom);
            end
        end
        @(negedge clk);
        sampleOutputs();
        modelCheck(0);
        modelCheck(1);
    endtask

    task automatic waitTag(input int d, input int limit);
        int  start = doneCount[d];
        int  n     = 0;
        bit  timedOut;
        while (doneCount[d] == start && n < limit) begin
            step();
            n++;
        end
        timedOut = (doneCount[d] == start);
        checkEq({dutName[d], ".timeout"}, timedOut, 1'b0);
    endtask

    task automatic idleReq();
        for (int d = 0; d < 2; d++) begin
            missReq[d] = 1'b0; spurReq[d] = 1'b0; latModeReq[d] = 0;
            missAddrReq[d] = 16'h0;
        end
    endtask

    initial begin
        int c0, c1, n;
        for (int d = 0; d < 2; d++) begin
            missDrv[d] = 1'b0; missAddrDrv[d] = 16'h0; memValidDrv[d] = 1'b0; memDataDrv[d] = 16'h0;
            inFill[d] = 1'b0; issued[d] = 0; rcvd[d] = 0; base[d] = 16'h0; lastAddr[d] = 16'h0;
            justDone[d] = 1'b0; doneCount[d] = 0; tagCycle[d] = 0;
            memIssued[d] = 0; memReturned[d] = 0; lastReady[d] = 0; latMode[d] = 0; salt[d] = 16'h0;
        end
        idleReq();

        // reset
        rstReq = 1'b1;
        step();
        step();
        rstReq = 1'b0;
        step();
        checkEq("bw8.rstIdx", obsIdx[0], 0);
        checkEq("bw4.rstIdx", obsIdx[1], 0);

        // basic fill on both block sizes, fixed 4-cycle latency
        missReq[0] = 1'b1; missAddrReq[0] = 16'h1234;
        missReq[1] = 1'b1; missAddrReq[1] = 16'h00AB;
        step();
        c0 = cyc;
        idleReq();
        waitTag(0, 40);
        checkEq("bw8.basicTagCycle", tagCycle[0] - c0, 12);
        checkEq("bw4.basicTagCycle", tagCycle[1] - c0, 8);

        // back-to-back miss with a 3-cycle return gap after word 2
        missReq[0] = 1'b1; missAddrReq[0] = 16'h0040; latModeReq[0] = 2;
        step();
        c1 = cyc;
        idleReq();
        waitTag(0, 40);
        checkEq("bw8.gapTagCycle", tagCycle[0] - c1, 15);

        // spurious memory_valid while idle
        spurReq[0] = 1'b1; spurReq[1] = 1'b1;
        repeat (6) step();
        idleReq();

        // reset after three words have returned, then a fill at the top of memory
        missReq[0] = 1'b1; missAddrReq[0] = 16'h5555;
        step();
        idleReq();
        n = 0;
        while (rcvd[0] < 3 && n < 40) begin
            step();
            n++;
        end
        checkEq("bw8.midWords", rcvd[0], 3);
        rstReq = 1'b1;
        step();
        rstReq = 1'b0;
        step();
        missReq[0] = 1'b1; missAddrReq[0] = 16'hFFF6;
        step();
        idleReq();
        waitTag(0, 40);
        checkEq("bw8.topLastAddr", obsAddr[0], 16'hFFFE);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rstReq = ($urandom_range(0, 499) == 0);
            for (int d = 0; d < 2; d++) begin
                if (inFill[d]) begin
                    missReq[d] = 1'($urandom_range(0, 1));
                    spurReq[d] = 1'b0;
                end else begin
                    missReq[d] = justDone[d] ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 3) == 0);
                    spurReq[d] = ($urandom_range(0, 3) == 0);
                end
                missAddrReq[d] = ($urandom_range(0, 7) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                                             : 16'($urandom);
                latModeReq[d] = $urandom_range(0, 2);
            end
            step();
        end
        rstReq = 1'b0;
        idleReq();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
